// File: rtl/arranque_rampa_param_pkg.sv
// Shared definitions for the parametrised soft-start ramp controller family:
// state/mode encodings and the level arithmetic used by the drive blocks.
package arranque_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  // Rapido outranks Lento; neither selected means the ramp pauses.
  typedef enum logic [1:0] {
    MODE_PAUSE = 2'd0,
    MODE_FAST  = 2'd1,
    MODE_SLOW  = 2'd2
  } mode_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned max_level(input int unsigned level_w);
    return (32'd1 << level_w) - 1;
  endfunction

  function automatic int unsigned step_size(input int unsigned level_w,
                                            input int unsigned n_steps);
    return max_level(level_w) / n_steps;
  endfunction

  function automatic int unsigned level_for(input int unsigned stage,
                                            input int unsigned n_steps,
                                            input int unsigned level_w);
    if (stage == 0) return 0;
    if (stage >= n_steps) return max_level(level_w);
    return stage * step_size(level_w, n_steps);
  endfunction

  function automatic mode_t select_mode(input logic rapido, input logic lento);
    if (rapido) return MODE_FAST;
    if (lento) return MODE_SLOW;
    return MODE_PAUSE;
  endfunction

endpackage

// File: rtl/arranque_rampa_param_pwm_gen.sv
// Free-running PWM: counter 0..MAX-1, output high while counter < level.
module pwm_gen
  import arranque_pkg::*;
#(
  parameter int unsigned LEVEL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LEVEL_W-1:0] level,
  output logic               pwm_out
);

  localparam logic [LEVEL_W-1:0] CNT_LAST = LEVEL_W'(max_level(LEVEL_W) - 1);

  logic [LEVEL_W-1:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= (pwm_cnt == CNT_LAST) ? '0 : pwm_cnt + LEVEL_W'(1);
      pwm_out <= (pwm_cnt < level);
    end
  end

endmodule

// File: rtl/arranque_rampa_param.sv
// Soft-start/soft-stop ramp controller: N_STEPS equal level increments with
// mode-selected dwell, symmetric ramp-down, emergency stop and PWM drive.
module arranque_rampa_param
  import arranque_pkg::*;
#(
  parameter int unsigned N_STEPS    = 4,
  parameter int unsigned LEVEL_W    = 8,
  parameter int unsigned DWELL_W    = 16,
  parameter int unsigned DWELL_FAST = 1000,
  parameter int unsigned DWELL_SLOW = 4000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             stop,
  input  logic                             estop,
  input  logic                             Rapido,
  input  logic                             Lento,
  output logic [LEVEL_W-1:0]               level,
  output logic [clog2(N_STEPS + 1)-1:0]    stage,
  output logic                             pwm_out,
  output logic                             busy,
  output logic                             full_speed,
  output logic                             done
);

  localparam int unsigned        STAGE_W    = clog2(N_STEPS + 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(N_STEPS);
  localparam logic [STAGE_W-1:0] ONE_STAGE  = STAGE_W'(1);
  localparam logic [DWELL_W-1:0] FAST_LAST  = DWELL_W'(DWELL_FAST - 1);
  localparam logic [DWELL_W-1:0] SLOW_LAST  = DWELL_W'(DWELL_SLOW - 1);

  state_t             state, state_n;
  mode_t              mode;
  logic [STAGE_W-1:0] stage_n;
  logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_n, dwell_last, dwell_tick;
  logic               mode_on, advance, done_n;

  // >= rather than == so a switch to a shorter dwell advances on the next active cycle.
  always_comb begin
    mode       = select_mode(Rapido, Lento);
    mode_on    = (mode != MODE_PAUSE);
    dwell_last = (mode == MODE_SLOW) ? SLOW_LAST : FAST_LAST;
    advance    = mode_on && (dwell_cnt >= dwell_last);
    dwell_tick = mode_on ? dwell_cnt + DWELL_W'(1) : dwell_cnt;
  end

  always_comb begin
    state_n     = state;
    stage_n     = stage;
    dwell_cnt_n = dwell_cnt;
    done_n      = 1'b0;
    if (estop) begin
      state_n     = IDLE;
      stage_n     = '0;
      dwell_cnt_n = '0;
    end else begin
      case (state)
        IDLE: begin
          dwell_cnt_n = '0;
          if (start && !stop) begin
            state_n = RAMP_UP;
            stage_n = ONE_STAGE;
          end
        end
        RAMP_UP: begin
          if (stop) begin
            state_n     = RAMP_DOWN;
            dwell_cnt_n = '0;
          end else if (advance) begin
            stage_n     = stage + ONE_STAGE;
            dwell_cnt_n = '0;
            if (stage + ONE_STAGE == LAST_STAGE) state_n = RUN;
          end else begin
            dwell_cnt_n = dwell_tick;
          end
        end
        RUN: begin
          dwell_cnt_n = '0;
          if (stop) state_n = RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (start && !stop) begin
            // A reversal before the first down-step is already at full scale.
            state_n     = (stage == LAST_STAGE) ? RUN : RAMP_UP;
            dwell_cnt_n = '0;
          end else if (advance) begin
            stage_n     = stage - ONE_STAGE;
            dwell_cnt_n = '0;
            if (stage == ONE_STAGE) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end else begin
            dwell_cnt_n = dwell_tick;
          end
        end
        default: begin
          state_n     = IDLE;
          stage_n     = '0;
          dwell_cnt_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      stage     <= '0;
      level     <= '0;
      dwell_cnt <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      stage     <= stage_n;
      level     <= LEVEL_W'(level_for(32'(stage_n), N_STEPS, LEVEL_W));
      dwell_cnt <= dwell_cnt_n;
      done      <= done_n;
    end
  end

  assign busy       = (state == RAMP_UP) || (state == RAMP_DOWN);
  assign full_speed = (state == RUN);

  pwm_gen #(
    .LEVEL_W(LEVEL_W)
  ) u_pwm_gen (
    .clk    (clk),
    .reset  (reset),
    .level  (level),
    .pwm_out(pwm_out)
  );

endmodule

// File: tb/tb_arranque_rampa_param.sv
// Bench for arranque_rampa_param: directed ramp scenarios plus random stimulus,
// every cycle compared against a phase/elapsed-time reference model.
module tb_arranque_rampa_param;

  localparam int N    = 4;
  localparam int DF   = 4;
  localparam int DS   = 10;
  localparam int MAXV = 255;
  localparam int P_IDLE = 0, P_UP = 1, P_RUN = 2, P_DOWN = 3;

  logic       clk = 1'b0;
  logic       reset, start, stop, estop, Rapido, Lento;
  logic [7:0] level;
  logic [2:0] stage;
  logic       pwm_out, busy, full_speed, done;

  int n_vec = 0;
  int n_err = 0;
  int m_ph = P_IDLE, m_stage = 0, m_el = 0, m_level = 0;
  int m_pcnt = 0, m_pwm = 0, m_done = 0;

  always #5 clk = ~clk;

  arranque_rampa_param #(
    .N_STEPS   (N),
    .LEVEL_W   (8),
    .DWELL_W   (16),
    .DWELL_FAST(DF),
    .DWELL_SLOW(DS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .estop     (estop),
    .Rapido    (Rapido),
    .Lento     (Lento),
    .level     (level),
    .stage     (stage),
    .pwm_out   (pwm_out),
    .busy      (busy),
    .full_speed(full_speed),
    .done      (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
    n_vec++;
    if (got !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int level_of(input int s);
    if (s == 0) return 0;
    if (s >= N) return MAXV;
    return s * (MAXV / N);
  endfunction

  // Model: phase plus count of active dwell cycles spent in the current step.
  task automatic model_step();
    int dw;
    dw = Rapido ? DF : (Lento ? DS : 0);
    m_done = 0;
    if (reset) begin
      m_ph = P_IDLE; m_stage = 0; m_el = 0; m_pcnt = 0; m_pwm = 0;
    end else begin
      m_pwm  = (m_pcnt < m_level) ? 1 : 0;
      m_pcnt = (m_pcnt + 1) % MAXV;
      if (estop) begin
        m_ph = P_IDLE; m_stage = 0; m_el = 0;
      end else if (m_ph == P_IDLE) begin
        if (start && !stop) begin m_ph = P_UP; m_stage = 1; m_el = 0; end
      end else if (m_ph == P_UP) begin
        if (stop) begin m_ph = P_DOWN; m_el = 0; end
        else if (dw != 0) begin
          m_el++;
          if (m_el >= dw) begin
            m_el = 0; m_stage++;
            if (m_stage == N) m_ph = P_RUN;
          end
        end
      end else if (m_ph == P_RUN) begin
        if (stop) begin m_ph = P_DOWN; m_el = 0; end
      end else begin
        if (start && !stop) begin
          m_ph = (m_stage == N) ? P_RUN : P_UP; m_el = 0;
        end else if (dw != 0) begin
          m_el++;
          if (m_el >= dw) begin
            m_el = 0; m_stage--;
            if (m_stage == 0) begin m_ph = P_IDLE; m_done = 1; end
          end
        end
      end
    end
    m_level = level_of(m_stage);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("level", level, m_level);
    check_eq("stage", stage, m_stage);
    check_eq("pwm_out", pwm_out, m_pwm);
    check_eq("busy", busy, (m_ph == P_UP || m_ph == P_DOWN) ? 1 : 0);
    check_eq("full_speed", full_speed, (m_ph == P_RUN) ? 1 : 0);
    check_eq("done", done, m_done);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_in(input logic st, input logic sp, input logic es,
                        input logic r, input logic l);
    start = st; stop = sp; estop = es; Rapido = r; Lento = l;
  endtask

  task automatic count_pwm(input string tag, input int exp);
    int hi;
    hi = 0;
    for (int i = 0; i < MAXV; i++) begin
      tick();
      hi += int'(pwm_out);
    end
    check_eq(tag, hi, exp);
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0);
    run(2);
    reset = 1'b0;
    check_eq("rst_level", level, 0);
    check_eq("rst_busy", busy, 0);

    // Fast ramp up
    set_in(1, 0, 0, 1, 0);
    tick();
    check_eq("up_l1", level, 63);
    check_eq("up_s1", stage, 1);
    check_eq("up_busy", busy, 1);
    run(4); check_eq("up_l2", level, 126);
    run(4); check_eq("up_l3", level, 189);
    run(4); check_eq("up_l4", level, 255);
    check_eq("up_full", full_speed, 1);
    run(3); check_eq("run_hold", level, 255);

    // Ramp down from RUN
    set_in(0, 1, 0, 1, 0);
    tick(); check_eq("dn_l4", level, 255);
    run(4); check_eq("dn_l3", level, 189);
    run(4); check_eq("dn_l2", level, 126);
    run(4); check_eq("dn_l1", level, 63);
    run(4); check_eq("dn_l0", level, 0);
    check_eq("dn_done", done, 1);
    tick(); check_eq("dn_done_clr", done, 0);
    check_eq("dn_idle", busy, 0);

    // Emergency stop mid-ramp
    set_in(1, 0, 0, 1, 0);
    tick(); run(4); check_eq("es_pre", level, 126);
    estop = 1'b1;
    tick();
    check_eq("es_level", level, 0);
    check_eq("es_stage", stage, 0);
    check_eq("es_busy", busy, 0);
    check_eq("es_done", done, 0);
    run(5); check_eq("es_hold", stage, 0);
    set_in(0, 0, 0, 1, 0);
    tick();

    // Reversal from ramp-down at stage 2, then start+stop in RUN
    set_in(1, 0, 0, 1, 0);
    tick(); run(12); check_eq("rv_full", full_speed, 1);
    set_in(0, 1, 0, 1, 0);
    tick(); run(8); check_eq("rv_s2", stage, 2);
    set_in(1, 0, 0, 1, 0);
    tick(); check_eq("rv_busy", busy, 1); check_eq("rv_hold", level, 126);
    run(4); check_eq("rv_l3", level, 189);
    run(4); check_eq("rv_l4", full_speed, 1);
    set_in(1, 1, 0, 1, 0);
    tick(); check_eq("ss_down", busy, 1); check_eq("ss_full", full_speed, 0);
    set_in(0, 0, 0, 1, 0);
    run(20); check_eq("ss_idle", level, 0);

    // Slow ramp with a 5-cycle pause
    set_in(1, 0, 0, 0, 1);
    tick(); run(5);
    set_in(1, 0, 0, 0, 0);
    run(5); check_eq("pause_hold", level, 63);
    set_in(1, 0, 0, 0, 1);
    run(4); check_eq("pause_l1", level, 63);
    tick(); check_eq("pause_l2", level, 126);
    set_in(0, 0, 1, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0);
    tick();

    // PWM duty at 63, 255 and 0, with reset mid-period
    set_in(1, 0, 0, 1, 0);
    tick();
    set_in(0, 0, 0, 0, 0);
    run(3);
    count_pwm("pwm_63", 63);
    set_in(0, 0, 0, 1, 0);
    run(14);
    count_pwm("pwm_255", 255);
    run(17);
    reset = 1'b1;
    tick(); check_eq("rst_pwm", pwm_out, 0); check_eq("rst_lvl", level, 0);
    reset = 1'b0;
    count_pwm("pwm_0", 0);

    // Random stimulus
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        start  = ($urandom_range(0, 2) != 0);
        stop   = ($urandom_range(0, 3) == 0);
        Rapido = ($urandom_range(0, 1) == 1);
        Lento  = ($urandom_range(0, 2) != 0);
      end
      estop = ($urandom_range(0, 99) == 0);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
